// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator: extracts and extends the immediate of a 32-bit
// instruction word, then holds it in a 2-entry skid buffer with flush support.
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] SEL_I     = 3'd0;
    localparam logic [2:0] SEL_SHAMT = 3'd1;
    localparam logic [2:0] SEL_S     = 3'd2;
    localparam logic [2:0] SEL_B     = 3'd3;
    localparam logic [2:0] SEL_U     = 3'd4;
    localparam logic [2:0] SEL_J     = 3'd5;
    localparam logic [2:0] SEL_ZIMM  = 3'd6;

    logic [XLEN-1:0]  imm_new;
    logic             in_fire;
    logic             out_fire;

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q,   main_imm_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    // The opcode field plays no part in immediate selection.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    // Signed size casts replicate instr[31] up to XLEN without zero-width replications.
    always_comb begin
        // NOTE: a default assignment first in every always_comb keeps all paths
        // assigned, so no latch can be inferred.
        imm_new = '0;
        case (in_sel)
            SEL_I:     imm_new = XLEN'($signed(in_instr[31:20]));
            SEL_SHAMT: begin
                if (XLEN == 64) imm_new = XLEN'(in_instr[25:20]);
                else            imm_new = XLEN'(in_instr[24:20]);
            end
            SEL_S:     imm_new = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            SEL_B:     imm_new = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                                in_instr[11:8], 1'b0}));
            SEL_U:     imm_new = XLEN'($signed({in_instr[31:12], 12'b0}));
            SEL_J:     imm_new = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                                in_instr[30:21], 1'b0}));
            SEL_ZIMM:  imm_new = XLEN'(in_instr[19:15]);
            default:   imm_new = '0;
        endcase
    end

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_q && out_ready;

    assign out_valid = main_valid_q;
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;

        if (flush) begin
            // Squash wins over everything; the entry offered this cycle is dropped.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                skid_valid_d = in_fire;
                skid_imm_d   = imm_new;
                skid_tag_d   = in_tag;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_imm_d   = imm_new;
                main_tag_d   = in_tag;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = imm_new;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking assignments so
        // every flop samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // NOTE: skid payload needs no reset; it is never observed unless skid_valid_q is set.
    always_ff @(posedge clk) begin
        skid_imm_q <= skid_imm_d;
        skid_tag_q <= skid_tag_d;
    end

endmodule
